// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined RV32I control unit.
//
// Decodes a 32-bit instruction into a packed control bundle and carries the bundle and rd
// through the ID/EX, EX/MEM and MEM/WB registers. Load-use hazards insert LOAD_USE_BUBBLES
// bubbles into EX. stall_ext freezes every stage. flush discards the instruction being
// decoded. Reset is asynchronous and active high.
//
// Optional feature: define RV32M_EN to decode the M extension. CTRL_W becomes 25 and
// bit 24 is muldiv. Without it CTRL_W is 24 and the M encodings decode as illegal.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   in_valid, instr, in_ready  fetch handshake (accepted when in_valid & in_ready)
//   stall_ext                  global freeze of all stage registers and the bubble counter
//   flush                      kill the decoding instruction, bubble into EX
//   hazard_stall               a load-use bubble is being inserted this cycle
//   ex/mem/wb_ctrl             stage control bundles (CTRL_W bits)
//   ex/mem/wb_rd               stage destination registers (RD_W bits)
//
// Bundle: [0] RegWrite [1] MemRead [2] MemWrite [3] MemtoReg [4] ALUSrc [5] lui
//         [6] auipc [7] jal [8] jalr [14:9] beq,bne,blt,bge,bltu,bgeu [17:15] RW_type
//         [21:18] ALUctl [22] illegal [23] valid [24] muldiv (RV32M_EN only)
module ctrl_pipe #(
  parameter int unsigned RD_W             = 5,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
`ifdef RV32M_EN
  localparam int unsigned CTRL_W          = 25
`else
  localparam int unsigned CTRL_W          = 24
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  output logic              in_ready,
  input  logic              stall_ext,
  input  logic              flush,
  output logic              hazard_stall,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [RD_W-1:0]   ex_rd,
  output logic [RD_W-1:0]   mem_rd,
  output logic [RD_W-1:0]   wb_rd
);

  localparam int unsigned BitRegWrite = 0;
  localparam int unsigned BitMemRead  = 1;
  localparam int unsigned BitMemWrite = 2;
  localparam int unsigned BitMemtoReg = 3;
  localparam int unsigned BitAluSrc   = 4;
  localparam int unsigned BitLui      = 5;
  localparam int unsigned BitAuipc    = 6;
  localparam int unsigned BitJal      = 7;
  localparam int unsigned BitJalr     = 8;
  localparam int unsigned BitBeq      = 9;
  localparam int unsigned BitBne      = 10;
  localparam int unsigned BitBlt      = 11;
  localparam int unsigned BitBge      = 12;
  localparam int unsigned BitBltu     = 13;
  localparam int unsigned BitBgeu     = 14;
  localparam int unsigned BitRwLo     = 15;
  localparam int unsigned BitRwHi     = 17;
  localparam int unsigned BitAluLo    = 18;
  localparam int unsigned BitAluHi    = 21;
  localparam int unsigned BitIllegal  = 22;
  localparam int unsigned BitValid    = 23;
`ifdef RV32M_EN
  localparam int unsigned BitMulDiv   = 24;
`endif

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b1000;

  // First-hazard reload value: the hazard cycle itself is one bubble, cnt counts the rest.
  localparam logic [1:0] CntInit = (LOAD_USE_BUBBLES == 0) ? 2'd0 :
                                   2'(LOAD_USE_BUBBLES - 1);

  logic [6:0]        opcode;
  logic [2:0]        func3;
  logic [6:0]        func7;
  logic [RD_W-1:0]   rs1;
  logic [RD_W-1:0]   rs2;

  logic [CTRL_W-1:0] dec_ctrl;
  logic [RD_W-1:0]   dec_rd;
  logic              dec_legal;
  logic              use_rs1;
  logic              use_rs2;

  logic [1:0]        cnt_q, cnt_d;
  logic              hz;
  logic              ex_load;

  logic [CTRL_W-1:0] ex_ctrl_d, mem_ctrl_d, wb_ctrl_d;
  logic [RD_W-1:0]   ex_rd_d, mem_rd_d, wb_rd_d;

  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign func7  = instr[31:25];
  assign rs1    = instr[15 +: RD_W];
  assign rs2    = instr[20 +: RD_W];

  // Instruction decode
  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (opcode)
      OpR: begin
        use_rs1               = 1'b1;
        use_rs2               = 1'b1;
        dec_ctrl[BitRegWrite] = 1'b1;
        if (func7 == 7'b0000000) begin
          dec_ctrl[BitAluHi:BitAluLo] = {1'b0, func3};
        end else if (func7 == 7'b0100000 && (func3 == 3'b000 || func3 == 3'b101)) begin
          dec_ctrl[BitAluHi:BitAluLo] = {1'b1, func3};
`ifdef RV32M_EN
        end else if (func7 == 7'b0000001) begin
          dec_ctrl[BitMulDiv]         = 1'b1;
          dec_ctrl[BitAluHi:BitAluLo] = {1'b0, func3};
`endif
        end else begin
          dec_legal = 1'b0;
        end
      end
      OpImm: begin
        use_rs1                     = 1'b1;
        dec_ctrl[BitRegWrite]       = 1'b1;
        dec_ctrl[BitAluSrc]         = 1'b1;
        // Only SRAI carries the SUB/SRA select in instr[30]
        dec_ctrl[BitAluHi:BitAluLo] = {(func3 == 3'b101) & instr[30], func3};
      end
      OpLoad: begin
        use_rs1                     = 1'b1;
        dec_ctrl[BitRegWrite]       = 1'b1;
        dec_ctrl[BitMemRead]        = 1'b1;
        dec_ctrl[BitMemtoReg]       = 1'b1;
        dec_ctrl[BitAluSrc]         = 1'b1;
        dec_ctrl[BitRwHi:BitRwLo]   = func3;
        dec_ctrl[BitAluHi:BitAluLo] = AluAdd;
      end
      OpStore: begin
        use_rs1                     = 1'b1;
        use_rs2                     = 1'b1;
        dec_ctrl[BitMemWrite]       = 1'b1;
        dec_ctrl[BitAluSrc]         = 1'b1;
        dec_ctrl[BitRwHi:BitRwLo]   = func3;
        dec_ctrl[BitAluHi:BitAluLo] = AluAdd;
      end
      OpBranch: begin
        use_rs1                     = 1'b1;
        use_rs2                     = 1'b1;
        dec_ctrl[BitAluHi:BitAluLo] = AluSub;
        case (func3)
          3'b000:  dec_ctrl[BitBeq]  = 1'b1;
          3'b001:  dec_ctrl[BitBne]  = 1'b1;
          3'b100:  dec_ctrl[BitBlt]  = 1'b1;
          3'b101:  dec_ctrl[BitBge]  = 1'b1;
          3'b110:  dec_ctrl[BitBltu] = 1'b1;
          3'b111:  dec_ctrl[BitBgeu] = 1'b1;
          default: ;
        endcase
      end
      OpJalr: begin
        use_rs1                     = 1'b1;
        dec_ctrl[BitRegWrite]       = 1'b1;
        dec_ctrl[BitJalr]           = 1'b1;
        dec_ctrl[BitAluSrc]         = 1'b1;
        dec_ctrl[BitAluHi:BitAluLo] = AluAdd;
      end
      OpJal: begin
        dec_ctrl[BitRegWrite]       = 1'b1;
        dec_ctrl[BitJal]            = 1'b1;
        dec_ctrl[BitAluHi:BitAluLo] = AluAdd;
      end
      OpLui: begin
        dec_ctrl[BitRegWrite]       = 1'b1;
        dec_ctrl[BitLui]            = 1'b1;
        dec_ctrl[BitAluSrc]         = 1'b1;
        dec_ctrl[BitAluHi:BitAluLo] = AluAdd;
      end
      OpAuipc: begin
        dec_ctrl[BitRegWrite]       = 1'b1;
        dec_ctrl[BitAuipc]          = 1'b1;
        dec_ctrl[BitAluSrc]         = 1'b1;
        dec_ctrl[BitAluHi:BitAluLo] = AluAdd;
      end
      default: dec_legal = 1'b0;
    endcase

    // Illegal words carry only valid+illegal and never count as register readers
    if (!dec_legal) begin
      dec_ctrl             = '0;
      dec_ctrl[BitIllegal] = 1'b1;
      use_rs1              = 1'b0;
      use_rs2              = 1'b0;
    end
    dec_ctrl[BitValid] = 1'b1;
  end

  assign dec_rd = dec_ctrl[BitRegWrite] ? instr[7 +: RD_W] : '0;

  // Load-use hazard against the instruction sitting in EX
  assign ex_load = ex_ctrl[BitValid] & ex_ctrl[BitMemRead] & (ex_rd != '0);
  assign hz      = (LOAD_USE_BUBBLES != 0) & in_valid & ex_load &
                   ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));

  assign hazard_stall = ((cnt_q == 2'd0) & hz) | (cnt_q != 2'd0);
  assign in_ready     = ~stall_ext & ~hazard_stall;

  // Next-state for the stage registers and bubble counter
  always_comb begin
    ex_ctrl_d  = ex_ctrl;
    ex_rd_d    = ex_rd;
    mem_ctrl_d = mem_ctrl;
    mem_rd_d   = mem_rd;
    wb_ctrl_d  = wb_ctrl;
    wb_rd_d    = wb_rd;
    cnt_d      = cnt_q;
    if (flush) begin
      // Flush overrides stall_ext for EX; MEM/WB still respect the freeze
      ex_ctrl_d = '0;
      ex_rd_d   = '0;
      cnt_d     = 2'd0;
      if (!stall_ext) begin
        mem_ctrl_d = ex_ctrl;
        mem_rd_d   = ex_rd;
        wb_ctrl_d  = mem_ctrl;
        wb_rd_d    = mem_rd;
      end
    end else if (!stall_ext) begin
      mem_ctrl_d = ex_ctrl;
      mem_rd_d   = ex_rd;
      wb_ctrl_d  = mem_ctrl;
      wb_rd_d    = mem_rd;
      if (hazard_stall) begin
        ex_ctrl_d = '0;
        ex_rd_d   = '0;
        cnt_d     = (cnt_q == 2'd0) ? CntInit : cnt_q - 2'd1;
      end else if (in_valid) begin
        ex_ctrl_d = dec_ctrl;
        ex_rd_d   = dec_rd;
      end else begin
        ex_ctrl_d = '0;
        ex_rd_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl  <= '0;
      ex_rd    <= '0;
      mem_ctrl <= '0;
      mem_rd   <= '0;
      wb_ctrl  <= '0;
      wb_rd    <= '0;
      cnt_q    <= 2'd0;
    end else begin
      ex_ctrl  <= ex_ctrl_d;
      ex_rd    <= ex_rd_d;
      mem_ctrl <= mem_ctrl_d;
      mem_rd   <= mem_rd_d;
      wb_ctrl  <= wb_ctrl_d;
      wb_rd    <= wb_rd_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: three instances (LOAD_USE_BUBBLES 0/1/3, the last with RD_W=4)
// share one input stream and are compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_ctrl_pipe;
`ifdef RV32M_EN
  localparam int CW = 25;
`else
  localparam int CW = 24;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, stall_ext, flush;
  logic [31:0] instr;

  always #5 clk = ~clk;

  logic          rdy0, rdy1, rdy3, hs0, hs1, hs3;
  logic [CW-1:0] exc0, memc0, wbc0, exc1, memc1, wbc1, exc3, memc3, wbc3;
  logic [4:0]    exr0, memr0, wbr0, exr1, memr1, wbr1;
  logic [3:0]    exr3, memr3, wbr3;

  ctrl_pipe #(.RD_W(5), .LOAD_USE_BUBBLES(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .in_ready(rdy0),
    .stall_ext(stall_ext), .flush(flush), .hazard_stall(hs0),
    .ex_ctrl(exc0), .mem_ctrl(memc0), .wb_ctrl(wbc0), .ex_rd(exr0), .mem_rd(memr0),
    .wb_rd(wbr0));
  ctrl_pipe #(.RD_W(5), .LOAD_USE_BUBBLES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .in_ready(rdy1),
    .stall_ext(stall_ext), .flush(flush), .hazard_stall(hs1),
    .ex_ctrl(exc1), .mem_ctrl(memc1), .wb_ctrl(wbc1), .ex_rd(exr1), .mem_rd(memr1),
    .wb_rd(wbr1));
  ctrl_pipe #(.RD_W(4), .LOAD_USE_BUBBLES(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .in_ready(rdy3),
    .stall_ext(stall_ext), .flush(flush), .hazard_stall(hs3),
    .ex_ctrl(exc3), .mem_ctrl(memc3), .wb_ctrl(wbc3), .ex_rd(exr3), .mem_rd(memr3),
    .wb_rd(wbr3));

  // Observed outputs gathered as [instance][stage]
  logic [CW-1:0] o_ctrl [3][3];
  logic [4:0]    o_rd   [3][3];
  logic          o_hs   [3];
  logic          o_rdy  [3];
  assign o_ctrl[0][0] = exc0; assign o_ctrl[0][1] = memc0; assign o_ctrl[0][2] = wbc0;
  assign o_ctrl[1][0] = exc1; assign o_ctrl[1][1] = memc1; assign o_ctrl[1][2] = wbc1;
  assign o_ctrl[2][0] = exc3; assign o_ctrl[2][1] = memc3; assign o_ctrl[2][2] = wbc3;
  assign o_rd[0][0] = exr0; assign o_rd[0][1] = memr0; assign o_rd[0][2] = wbr0;
  assign o_rd[1][0] = exr1; assign o_rd[1][1] = memr1; assign o_rd[1][2] = wbr1;
  assign o_rd[2][0] = {1'b0, exr3}; assign o_rd[2][1] = {1'b0, memr3};
  assign o_rd[2][2] = {1'b0, wbr3};
  assign o_hs[0] = hs0; assign o_hs[1] = hs1; assign o_hs[2] = hs3;
  assign o_rdy[0] = rdy0; assign o_rdy[1] = rdy1; assign o_rdy[2] = rdy3;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [4:0]    rd;
    logic          u1;
    logic          u2;
  } dec_t;

  // Model state: [instance][stage], plus bubbles still owed after the first one
  logic [CW-1:0] m_ctrl [3][3];
  logic [4:0]    m_rd   [3][3];
  int            m_owed [3];

  function automatic int lub_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  function automatic logic [4:0] mask_of(input int k);
    return (k == 2) ? 5'h0F : 5'h1F;
  endfunction

  // Reference decoder written from the instruction-set tables
  function automatic dec_t ref_decode(input logic [31:0] w, input int k);
    dec_t d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    d = '0; ok = 1'b1;
    case (op)
      7'h33: begin
        d.u1 = 1; d.u2 = 1; d.c[0] = 1;
        if (f7 == 7'h00) d.c[21:18] = {1'b0, f3};
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) d.c[21:18] = {1'b1, f3};
`ifdef RV32M_EN
        else if (f7 == 7'h01) begin d.c[24] = 1; d.c[21:18] = {1'b0, f3}; end
`endif
        else ok = 1'b0;
      end
      7'h13: begin
        d.u1 = 1; d.c[0] = 1; d.c[4] = 1;
        d.c[21:18] = {(f3 == 3'd5) && w[30], f3};
      end
      7'h03: begin d.u1 = 1; d.c[0] = 1; d.c[1] = 1; d.c[3] = 1; d.c[4] = 1; d.c[17:15] = f3; end
      7'h23: begin d.u1 = 1; d.u2 = 1; d.c[2] = 1; d.c[4] = 1; d.c[17:15] = f3; end
      7'h63: begin
        d.u1 = 1; d.u2 = 1; d.c[21:18] = 4'b1000;
        if (f3 == 3'd0) d.c[9] = 1;
        if (f3 == 3'd1) d.c[10] = 1;
        if (f3 >= 3'd4) d.c[11 + int'(f3) - 4] = 1;
      end
      7'h67: begin d.u1 = 1; d.c[0] = 1; d.c[8] = 1; d.c[4] = 1; end
      7'h6F: begin d.c[0] = 1; d.c[7] = 1; end
      7'h37: begin d.c[0] = 1; d.c[5] = 1; d.c[4] = 1; end
      7'h17: begin d.c[0] = 1; d.c[6] = 1; d.c[4] = 1; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin d = '0; d.c[22] = 1; end
    d.c[23] = 1;
    d.rd = d.c[0] ? (w[11:7] & mask_of(k)) : 5'd0;
    return d;
  endfunction

  function automatic bit model_stall(input int k);
    dec_t d;
    logic [4:0] m;
    bit hz;
    if (m_owed[k] != 0) return 1'b1;
    m = mask_of(k);
    d = ref_decode(instr, k);
    hz = (lub_of(k) != 0) && in_valid && m_ctrl[k][0][23] && m_ctrl[k][0][1] &&
         (m_rd[k][0] != 0) &&
         ((d.u1 && ((instr[19:15] & m) == m_rd[k][0])) ||
          (d.u2 && ((instr[24:20] & m) == m_rd[k][0])));
    return hz;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 3; s++) begin m_ctrl[k][s] = '0; m_rd[k][s] = '0; end
      m_owed[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit st;
      dec_t d;
      st = model_stall(k);
      d  = ref_decode(instr, k);
      if (flush || !stall_ext) begin
        if (!stall_ext) begin
          m_ctrl[k][2] = m_ctrl[k][1]; m_rd[k][2] = m_rd[k][1];
          m_ctrl[k][1] = m_ctrl[k][0]; m_rd[k][1] = m_rd[k][0];
        end
        if (flush) begin
          m_ctrl[k][0] = '0; m_rd[k][0] = '0; m_owed[k] = 0;
        end else if (st) begin
          m_ctrl[k][0] = '0; m_rd[k][0] = '0;
          m_owed[k] = (m_owed[k] == 0) ? lub_of(k) - 1 : m_owed[k] - 1;
        end else if (in_valid) begin
          m_ctrl[k][0] = d.c; m_rd[k][0] = d.rd;
        end else begin
          m_ctrl[k][0] = '0; m_rd[k][0] = '0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    string sn [3];
    sn[0] = "ex"; sn[1] = "mem"; sn[2] = "wb";
    for (int k = 0; k < 3; k++) begin
      bit st;
      st = model_stall(k);
      chk($sformatf("i%0d.hazard_stall", k), 32'(o_hs[k]), 32'(st));
      chk($sformatf("i%0d.in_ready", k), 32'(o_rdy[k]), 32'(!stall_ext && !st));
      for (int s = 0; s < 3; s++) begin
        chk($sformatf("i%0d.%s_ctrl", k, sn[s]), 32'(o_ctrl[k][s]), 32'(m_ctrl[k][s]));
        chk($sformatf("i%0d.%s_rd", k, sn[s]), 32'(o_rd[k][s]), 32'(m_rd[k][s]));
      end
    end
  endtask

  // Check before the edge, advance the model at the edge, return just after it
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11];
    logic [31:0] w;
    int sel;
    ops = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h33};
    w = $urandom;
    w[11:7] = rnd_reg(); w[19:15] = rnd_reg(); w[24:20] = rnd_reg();
    sel = $urandom_range(0, 12);
    if (sel < 11) w[6:0] = ops[sel];
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  localparam logic [31:0] IAddi = 32'h00500093;
  localparam logic [31:0] ILw   = 32'h0000A103;
  localparam logic [31:0] IAdd  = 32'h001101B3;
  localparam logic [31:0] ISw   = 32'h0020A223;
  localparam logic [31:0] IMul  = 32'h022081B3;
`ifdef RV32M_EN
  localparam logic [31:0] MulCtrl = 32'h1800001;
  localparam logic [31:0] MulRd   = 32'd3;
`else
  localparam logic [31:0] MulCtrl = 32'h0C00000;
  localparam logic [31:0] MulRd   = 32'd0;
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; stall_ext = 1'b0; flush = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all();
    rst = 1'b0;

    // addi x1,x0,5 through the pipe
    in_valid = 1'b1; instr = IAddi; cycle();
    chk("addi_ex_ctrl", 32'(exc1), 32'h800011);
    chk("addi_ex_rd", 32'(exr1), 32'd1);
    in_valid = 1'b0; cycle(); cycle();
    chk("addi_wb_ctrl", 32'(wbc1), 32'h800011);

    // lw x2 then add x3,x2,x1
    in_valid = 1'b1; instr = ILw; cycle();
    chk("lw_ex_ctrl", 32'(exc1), 32'h81001B);
    instr = IAdd; #1;
    chk("lu1_hazard", 32'(hs1), 32'd1);
    chk("lu1_ready", 32'(rdy1), 32'd0);
    chk("lu0_hazard", 32'(hs0), 32'd0);
    cycle();
    chk("lu1_bubble", 32'(exc1), 32'd0);
    chk("lu1_hz_clear", 32'(hs1), 32'd0);
    chk("lu0_add_rd", 32'(exr0), 32'd3);
    cycle();
    chk("lu1_add_rd", 32'(exr1), 32'd3);
    chk("lu3_still", 32'(hs3), 32'd1);
    cycle(); cycle();
    chk("lu3_add_rd", 32'(exr3), 32'd3);
    chk("lu3_add_ctrl", 32'(exc3), 32'h800001);

    // sw then two frozen cycles
    instr = ISw; cycle();
    chk("sw_ex_ctrl", 32'(exc1), 32'h810014);
    chk("sw_ex_rd", 32'(exr1), 32'd0);
    stall_ext = 1'b1; instr = IAddi; cycle(); cycle();
    chk("stall_ex_ctrl", 32'(exc1), 32'h810014);
    stall_ext = 1'b0;

    // flush under stall while a load-use consumer decodes
    instr = ILw; cycle();
    instr = IAdd; flush = 1'b1; stall_ext = 1'b1; cycle();
    chk("flush_ex_ctrl", 32'(exc3), 32'd0);
    chk("flush_no_stall", 32'(hs3), 32'd0);
    flush = 1'b0; stall_ext = 1'b0;
    instr = 32'h00000000; cycle();
    chk("zero_illegal", 32'(exc1), 32'hC00000);
    chk("zero_rd", 32'(exr1), 32'd0);
    instr = IMul; cycle();
    chk("mul_ctrl", 32'(exc1), MulCtrl);
    chk("mul_rd", 32'(exr1), MulRd);

    // Random traffic with one asynchronous mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 7) != 0);
      instr     = rand_instr();
      stall_ext = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      cycle();
      if (i == 1500) begin
        #2; rst = 1'b1; #1;
        model_reset();
        check_all();
        cycle();
        rst = 1'b0;
      end
    end

    in_valid = 1'b0; stall_ext = 1'b0; flush = 1'b0;
    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
